// File: rtl/turn_sequencer.sv
// turn_sequencer: Snakes and Ladders turn scheduler, token stepper, jump resolver and winner detector
module turn_sequencer #(
  parameter int NUM_PLAYERS  = 4,
  parameter int BOARD_LAST   = 100,
  parameter int POS_W        = 7,
  parameter bit EXACT_FINISH = 1
) (
  input  logic                         clock,
  input  logic                         resetn,
  input  logic                         start,
  input  logic                         roll,
  input  logic [2:0]                   dice,
  input  logic                         step_tick,
  output logic [POS_W-1:0]             jump_addr,
  input  logic [POS_W-1:0]             jump_dest,
  output logic [NUM_PLAYERS*POS_W-1:0] positions,
  output logic [1:0]                   cur_player,
  output logic                         busy,
  output logic [3:0]                   winner
);
  typedef enum logic [2:0] {IDLE, WAIT_ROLL, MOVE, JUMP, NEXT, WIN} state_t;
  localparam logic [POS_W-1:0] LAST = POS_W'(BOARD_LAST);
  state_t                  state;
  logic [3:0][POS_W-1:0]   pos;
  logic [2:0]              steps;
  logic [POS_W:0]          sum;
  logic [POS_W-1:0]        np;
  logic                    dice_ok;
  always_comb begin
    jump_addr = pos[cur_player];
    sum       = {1'b0, jump_addr} + (POS_W+1)'(dice);
    dice_ok   = dice != 3'd0 && dice != 3'd7;
    // out-of-range or zero lookup results are treated as "no snake/ladder"
    np        = (jump_dest != '0 && jump_dest <= LAST) ? jump_dest : jump_addr;
    positions = pos[NUM_PLAYERS-1:0];
  end
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state      <= IDLE;
      pos        <= '0;
      cur_player <= 2'd0;
      winner     <= 4'd0;
      busy       <= 1'b0;
      steps      <= 3'd0;
    end else begin
      case (state)
        IDLE: if (start) state <= WAIT_ROLL;
        WAIT_ROLL: if (roll && dice_ok) begin
          if (sum <= {1'b0, LAST}) begin
            steps <= dice;
            state <= MOVE;
            busy  <= 1'b1;
          end else if (EXACT_FINISH) begin
            state <= NEXT;
          end else begin
            steps <= 3'(LAST - jump_addr);
            state <= MOVE;
            busy  <= 1'b1;
          end
        end
        MOVE: if (step_tick) begin
          pos[cur_player] <= jump_addr + 1'b1;
          steps           <= steps - 3'd1;
          if (steps == 3'd1) state <= JUMP;
        end
        JUMP: begin
          pos[cur_player] <= np;
          busy            <= 1'b0;
          if (np == LAST) begin
            state  <= WIN;
            winner <= {2'b00, cur_player} + 4'd1;
          end else begin
            state <= NEXT;
          end
        end
        NEXT: begin
          cur_player <= (cur_player == 2'(NUM_PLAYERS-1)) ? 2'd0 : cur_player + 2'd1;
          state      <= WAIT_ROLL;
        end
        WIN: if (start) begin
          pos        <= '0;
          winner     <= 4'd0;
          cur_player <= 2'd0;
          state      <= WAIT_ROLL;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_turn_sequencer.sv
// tb_turn_sequencer: directed checks of a 4-player exact-finish game and a 3-player clamping game
module tb_turn_sequencer;
  logic        clock, resetn;
  logic        start_a, roll_a, tick_a, start_b, roll_b, tick_b;
  logic [2:0]  dice_a, dice_b;
  logic [6:0]  jaddr_a, jdest_a, jaddr_b, jdest_b;
  logic [27:0] pos_a;
  logic [20:0] pos_b;
  logic [1:0]  cur_a, cur_b;
  logic        busy_a, busy_b;
  logic [3:0]  win_a, win_b;
  logic        lad;
  int          total, passed, failed;

  turn_sequencer dut_a (
    .clock(clock), .resetn(resetn), .start(start_a), .roll(roll_a), .dice(dice_a),
    .step_tick(tick_a), .jump_addr(jaddr_a), .jump_dest(jdest_a), .positions(pos_a),
    .cur_player(cur_a), .busy(busy_a), .winner(win_a)
  );

  turn_sequencer #(.NUM_PLAYERS(3), .EXACT_FINISH(1'b0)) dut_b (
    .clock(clock), .resetn(resetn), .start(start_b), .roll(roll_b), .dice(dice_b),
    .step_tick(tick_b), .jump_addr(jaddr_b), .jump_dest(jdest_b), .positions(pos_b),
    .cur_player(cur_b), .busy(busy_b), .winner(win_b)
  );

  // board: ladders 4->14, 5->98, 16->97; snake 17->7; bad entries 3->120, 2->0
  function automatic logic [6:0] board(input logic [6:0] a, input logic en);
    if (!en) return a;
    case (a)
      7'd4:    return 7'd14;
      7'd5:    return 7'd98;
      7'd16:   return 7'd97;
      7'd17:   return 7'd7;
      7'd3:    return 7'd120;
      7'd2:    return 7'd0;
      default: return a;
    endcase
  endfunction

  always_comb begin
    jdest_a = board(jaddr_a, lad);
    jdest_b = board(jaddr_b, lad);
  end

  initial begin
    clock = 0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  task automatic edge1();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pa(input int p);
    return 32'(pos_a[p*7 +: 7]);
  endfunction

  function automatic logic [31:0] pb(input int p);
    return 32'(pos_b[p*7 +: 7]);
  endfunction

  task automatic start_in(input bit b);
    if (b) start_b = 1; else start_a = 1;
    edge1();
    start_a = 0;
    start_b = 0;
  endtask

  task automatic roll_in(input bit b, input int d);
    if (b) begin roll_b = 1; dice_b = 3'(d); end
    else begin roll_a = 1; dice_a = 3'(d); end
    edge1();
    roll_a = 0;
    roll_b = 0;
  endtask

  task automatic ticks(input bit b, input int n);
    for (int i = 0; i < n; i++) begin
      if (b) tick_b = 1; else tick_a = 1;
      edge1();
    end
    tick_a = 0;
    tick_b = 0;
  endtask

  task automatic turn(input bit b, input int d, input int n);
    roll_in(b, d);
    ticks(b, n);
    edge1();
    edge1();
  endtask

  initial begin
    total = 0; passed = 0; failed = 0; lad = 0;
    resetn = 0;
    start_a = 0; roll_a = 0; tick_a = 0; dice_a = 0;
    start_b = 0; roll_b = 0; tick_b = 0; dice_b = 0;
    edge1();
    edge1();
    chk("rst_pos", 32'(pos_a), 0);
    chk("rst_cur", 32'(cur_a), 0);
    chk("rst_win", 32'(win_a), 0);
    chk("rst_busy", 32'(busy_a), 0);
    chk("rst_pos_b", 32'(pos_b), 0);
    resetn = 1;
    roll_in(0, 3);
    ticks(0, 1);
    chk("idle_roll_busy", 32'(busy_a), 0);
    chk("idle_roll_pos", 32'(pos_a), 0);
    // basic turn with identity lookup
    start_in(0);
    roll_in(0, 4);
    chk("move_busy", 32'(busy_a), 1);
    ticks(0, 4);
    chk("jump_busy", 32'(busy_a), 1);
    chk("jump_pos0", pa(0), 4);
    edge1();
    chk("next_busy", 32'(busy_a), 0);
    chk("next_cur", 32'(cur_a), 0);
    edge1();
    chk("t1_cur", 32'(cur_a), 1);
    chk("t1_win", 32'(win_a), 0);
    // tick coincident with the roll is ignored
    tick_a = 1;
    roll_in(0, 2);
    tick_a = 0;
    chk("roll_tick_pos1", pa(1), 0);
    ticks(0, 2);
    edge1();
    edge1();
    chk("t2_pos1", pa(1), 2);
    chk("t2_cur", 32'(cur_a), 2);
    roll_in(0, 0);
    chk("dice0_busy", 32'(busy_a), 0);
    roll_in(0, 7);
    chk("dice7_busy", 32'(busy_a), 0);
    chk("dice7_cur", 32'(cur_a), 2);
    turn(0, 1, 1);
    chk("t3_pos2", pa(2), 1);
    turn(0, 1, 1);
    chk("wrap_cur", 32'(cur_a), 0);
    chk("t4_pos3", pa(3), 1);
    // reset in the middle of a move
    roll_in(0, 5);
    ticks(0, 2);
    chk("mid_pos0", pa(0), 6);
    chk("mid_busy", 32'(busy_a), 1);
    resetn = 0;
    edge1();
    chk("midrst_pos", 32'(pos_a), 0);
    chk("midrst_busy", 32'(busy_a), 0);
    chk("midrst_cur", 32'(cur_a), 0);
    resetn = 1;
    roll_in(0, 3);
    ticks(0, 2);
    chk("postrst_busy", 32'(busy_a), 0);
    chk("postrst_pos", 32'(pos_a), 0);
    // snakes, ladders and bad table entries
    lad = 1;
    start_in(0);
    turn(0, 4, 4);
    chk("ladder_pos0", pa(0), 14);
    turn(0, 1, 1);
    turn(0, 1, 1);
    turn(0, 1, 1);
    turn(0, 3, 3);
    chk("snake_pos0", pa(0), 7);
    turn(0, 2, 2);
    chk("bad120_pos1", pa(1), 3);
    turn(0, 1, 1);
    chk("bad0_pos2", pa(2), 2);
    turn(0, 4, 4);
    chk("ladder98_pos3", pa(3), 98);
    turn(0, 1, 1);
    turn(0, 1, 1);
    chk("ladder_pos1", pa(1), 14);
    turn(0, 1, 1);
    chk("pre_over_cur", 32'(cur_a), 3);
    // exact finish: overshoot forfeits the move without consuming ticks
    roll_in(0, 5);
    chk("over_busy", 32'(busy_a), 0);
    edge1();
    chk("over_cur", 32'(cur_a), 0);
    chk("over_pos3", pa(3), 98);
    turn(0, 1, 1);
    turn(0, 2, 2);
    chk("ladder97_pos1", pa(1), 97);
    turn(0, 1, 1);
    turn(0, 1, 1);
    chk("p3_99", pa(3), 99);
    turn(0, 1, 1);
    chk("pre_win_cur", 32'(cur_a), 1);
    turn(0, 3, 3);
    chk("win_val", 32'(win_a), 2);
    chk("win_cur", 32'(cur_a), 1);
    chk("win_pos1", pa(1), 100);
    chk("win_busy", 32'(busy_a), 0);
    roll_in(0, 1);
    ticks(0, 2);
    edge1();
    chk("win_hold", 32'(win_a), 2);
    chk("win_hold_cur", 32'(cur_a), 1);
    chk("win_hold_pos0", pa(0), 10);
    chk("win_hold_busy", 32'(busy_a), 0);
    start_in(0);
    chk("restart_pos", 32'(pos_a), 0);
    chk("restart_win", 32'(win_a), 0);
    chk("restart_cur", 32'(cur_a), 0);
    turn(0, 1, 1);
    chk("restart_play", pa(0), 1);
    chk("restart_play_cur", 32'(cur_a), 1);
    // three players, clamping finish
    start_in(1);
    turn(1, 5, 5);
    chk("b_pos0", pb(0), 98);
    turn(1, 1, 1);
    turn(1, 1, 1);
    chk("b_pos2", pb(2), 1);
    chk("b_wrap_cur", 32'(cur_b), 0);
    roll_in(1, 0);
    roll_in(1, 7);
    chk("b_bad_dice_busy", 32'(busy_b), 0);
    chk("b_bad_dice_cur", 32'(cur_b), 0);
    roll_in(1, 5);
    chk("b_clamp_busy", 32'(busy_b), 1);
    ticks(1, 1);
    chk("b_clamp_pos", pb(0), 99);
    chk("b_clamp_busy2", 32'(busy_b), 1);
    ticks(1, 1);
    chk("b_jump_pos", pb(0), 100);
    chk("b_jump_busy", 32'(busy_b), 1);
    edge1();
    chk("b_win", 32'(win_b), 1);
    chk("b_win_busy", 32'(busy_b), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
